// File: rtl/qvalue_engine_if.sv
// Request/result bundle for qvalue_engine: operands and start in, status and Q results out.
interface qvalue_engine_if #(parameter int WORD_WIDTH = 16);
    logic                  start;
    logic                  mode;
    logic [WORD_WIDTH-1:0] myEnergy, minEnergy, maxEnergy, hopsFromSink;
    logic [WORD_WIDTH-1:0] oldQ, bestQ, reward, alpha, gamma;
    logic                  busy;
    logic                  done;
    logic                  div_error;
    logic [WORD_WIDTH-1:0] myQValue, quotient_hop, quotient_energy;

    modport master (
        output start, mode, myEnergy, minEnergy, maxEnergy, hopsFromSink,
               oldQ, bestQ, reward, alpha, gamma,
        input  busy, done, div_error, myQValue, quotient_hop, quotient_energy
    );
    modport slave (
        input  start, mode, myEnergy, minEnergy, maxEnergy, hopsFromSink,
               oldQ, bestQ, reward, alpha, gamma,
        output busy, done, div_error, myQValue, quotient_hop, quotient_energy
    );
endinterface

// File: rtl/qvalue_engine.sv
// Sequential fixed-point Q-value engine: initial Q via shared restoring divider, or Q-learning update.
// Optional energy term enabled by defining QVALUE_ENERGY_TERM_EN.
module qvalue_engine #(
    parameter int WORD_WIDTH = 16,
    parameter int FRAC_BITS  = 12
) (
    input logic            clk,
    input logic            rst,
    qvalue_engine_if.slave bus
);
    localparam int W        = WORD_WIDTH;
    localparam int DIV_BITS = WORD_WIDTH + FRAC_BITS;
    localparam int CW       = $clog2(DIV_BITS);
    localparam logic [W:0]          ONE     = {{W{1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [DIV_BITS-1:0] HOP_DVD = {{(DIV_BITS-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [2:0] {IDLE, DIV_HOP, DIV_EN, COMBINE, UPD_MUL, UPD_ACC, DONE} state_t;
    state_t state, state_n;

    // "first" marks the setup cycle of DIV_HOP and the product cycle of UPD_ACC
    logic                first, err;
    logic [W-1:0]        hops_q, oldq_q, bestq_q, reward_q, alpha_q, gamma_q;
    logic [W-1:0]        rem, dvs, qhop, qval;
    logic [DIV_BITS-1:0] dq;
    logic [CW-1:0]       cnt;
    logic [2*W-1:0]      prod_g;
    logic [2*W:0]        pa, pb;

    logic [W:0]          trial;
    logic                ge, div_last;
    logic [W-1:0]        rem_n, target, newq, qsum;
    logic [DIV_BITS-1:0] q_next;
    logic [W:0]          alpha_c;
    logic [2*W:0]        target_w;
    logic [2*W+1:0]      acc;

    // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
    always_comb begin
        trial    = {rem, dq[DIV_BITS-1]};
        ge       = trial >= {1'b0, dvs};
        rem_n    = ge ? (trial[W-1:0] - dvs) : trial[W-1:0];
        q_next   = {dq[DIV_BITS-2:0], ge};
        div_last = (cnt == CW'(DIV_BITS - 1));
    end

    always_comb begin
        alpha_c  = ({1'b0, alpha_q} > ONE) ? ONE : {1'b0, alpha_q};
        target_w = {{(W+1){1'b0}}, reward_q} + {1'b0, prod_g >> FRAC_BITS};
        target   = (|target_w[2*W:W]) ? {W{1'b1}} : target_w[W-1:0];
        acc      = {1'b0, pa} + {1'b0, pb};
        acc      = acc >> FRAC_BITS;
        newq     = (|acc[2*W+1:W]) ? {W{1'b1}} : acc[W-1:0];
    end

`ifdef QVALUE_ENERGY_TERM_EN
    logic [W-1:0]        mye_q, mine_q, maxe_q, qen, en_clamp, en_dvs;
    logic [DIV_BITS-1:0] en_dvd;
    logic                en_lo, en_skip;
    logic [W:0]          qpair;

    always_comb begin
        en_lo    = mye_q <= mine_q;
        en_skip  = en_lo || (mye_q >= maxe_q) || (maxe_q <= mine_q);
        en_clamp = en_lo ? '0 : ONE[W-1:0];
        en_dvd   = {{FRAC_BITS{1'b0}}, mye_q - mine_q} << FRAC_BITS;
        en_dvs   = maxe_q - mine_q;
        qpair    = {1'b0, qhop} + {1'b0, qen};
        qsum     = qpair[W:1];
    end
`else
    logic unused_energy;
    assign unused_energy = ^{bus.myEnergy, bus.minEnergy, bus.maxEnergy};
    assign qsum = qhop;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = bus.mode ? UPD_MUL : DIV_HOP;
            DIV_HOP: begin
                if (first) begin
                    if (hops_q == '0) state_n = COMBINE;
                end else if (div_last) begin
`ifdef QVALUE_ENERGY_TERM_EN
                    state_n = en_skip ? COMBINE : DIV_EN;
`else
                    state_n = COMBINE;
`endif
                end
            end
`ifdef QVALUE_ENERGY_TERM_EN
            DIV_EN:  if (div_last) state_n = COMBINE;
`endif
            COMBINE: state_n = DONE;
            UPD_MUL: state_n = UPD_ACC;
            UPD_ACC: if (!first) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first <= 1'b0; err <= 1'b0;
            hops_q <= '0; oldq_q <= '0; bestq_q <= '0; reward_q <= '0; alpha_q <= '0; gamma_q <= '0;
            rem <= '0; dvs <= '0; dq <= '0; cnt <= '0;
            prod_g <= '0; pa <= '0; pb <= '0; qhop <= '0; qval <= '0;
`ifdef QVALUE_ENERGY_TERM_EN
            mye_q <= '0; mine_q <= '0; maxe_q <= '0; qen <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    first <= 1'b1; err <= 1'b0;
                    hops_q <= bus.hopsFromSink; oldq_q <= bus.oldQ; bestq_q <= bus.bestQ;
                    reward_q <= bus.reward; alpha_q <= bus.alpha; gamma_q <= bus.gamma;
`ifdef QVALUE_ENERGY_TERM_EN
                    mye_q <= bus.myEnergy; mine_q <= bus.minEnergy; maxe_q <= bus.maxEnergy;
`endif
                end
                DIV_HOP: begin
                    if (first) begin
                        first <= 1'b0;
                        if (hops_q == '0) begin
                            err  <= 1'b1;
                            qhop <= '0;
`ifdef QVALUE_ENERGY_TERM_EN
                            qen  <= '0;
`endif
                        end else begin
                            rem <= '0; dq <= HOP_DVD; dvs <= hops_q; cnt <= '0;
                        end
                    end else begin
                        rem <= rem_n; dq <= q_next; cnt <= cnt + 1'b1;
                        if (div_last) begin
                            qhop <= q_next[W-1:0];
`ifdef QVALUE_ENERGY_TERM_EN
                            if (en_skip) qen <= en_clamp;
                            else begin
                                rem <= '0; dq <= en_dvd; dvs <= en_dvs; cnt <= '0;
                            end
`endif
                        end
                    end
                end
`ifdef QVALUE_ENERGY_TERM_EN
                DIV_EN: begin
                    rem <= rem_n; dq <= q_next; cnt <= cnt + 1'b1;
                    if (div_last) qen <= q_next[W-1:0];
                end
`endif
                COMBINE: qval <= err ? '0 : qsum;
                UPD_MUL: prod_g <= gamma_q * bestq_q;
                UPD_ACC: begin
                    if (first) begin
                        first <= 1'b0;
                        pa    <= (ONE - alpha_c) * oldq_q;
                        pb    <= alpha_c * target;
                    end else begin
                        qval  <= newq;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.div_error    = (state == DONE) && err;
    assign bus.myQValue     = qval;
    assign bus.quotient_hop = qhop;
`ifdef QVALUE_ENERGY_TERM_EN
    assign bus.quotient_energy = qen;
`else
    assign bus.quotient_energy = '0;
`endif
endmodule

// File: tb/tb_qvalue_engine.sv
// Directed bench for qvalue_engine: expectations queued at start, checked when done pulses.
module tb_qvalue_engine;
`ifdef QVALUE_ENERGY_TERM_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qvalue_engine_if #(.WORD_WIDTH(16)) bus ();
    qvalue_engine #(.WORD_WIDTH(16), .FRAC_BITS(12)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        string       tag;
        logic [15:0] q, qh, qe;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [15:0] hops, mye, mine, maxe,
                         input logic [15:0] oq, bq, rw, al, gm);
        bus.mode = m; bus.hopsFromSink = hops; bus.myEnergy = mye; bus.minEnergy = mine;
        bus.maxEnergy = maxe; bus.oldQ = oq; bus.bestQ = bq; bus.reward = rw;
        bus.alpha = al; bus.gamma = gm;
    endtask

    // poke: 1 = stray start (different operands) mid-run, 2 = start during the done cycle
    task automatic run(input string tag, input logic m, input logic [15:0] hops, mye, mine, maxe,
                       input logic [15:0] oq, bq, rw, al, gm,
                       input logic [15:0] eq, eqh, eqe, input logic eerr, input int elat,
                       input int poke);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        drive(m, hops, mye, mine, maxe, oq, bq, rw, al, gm);
        bus.start = 1'b1;
        e = '{tag, eq, eqh, eqe, eerr, elat};
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "/busy"}, 32'(bus.busy), 32'd1);
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); n++; #1;
            if (poke == 1 && n == 5) begin
                drive(~m, 16'd7, 16'd1, 16'd0, 16'd2, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) got = 1'b1;
        end
        chk({tag, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            e = sb.pop_front();
            chk({e.tag, "/q"},   32'(bus.myQValue),        32'(e.q));
            chk({e.tag, "/qh"},  32'(bus.quotient_hop),    32'(e.qh));
            chk({e.tag, "/qe"},  32'(bus.quotient_energy), 32'(e.qe));
            chk({e.tag, "/err"}, 32'(bus.div_error),       32'(e.err));
            chk({e.tag, "/lat"}, 32'(n),                   32'(e.lat));
            if (poke == 2) begin
                bus.mode = 1'b1;
                bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk({e.tag, "/idle_busy"}, 32'(bus.busy), 32'd0);
            chk({e.tag, "/idle_done"}, 32'(bus.done), 32'd0);
            chk({e.tag, "/hold_q"},    32'(bus.myQValue), 32'(e.q));
        end
    endtask

    initial begin
        int seen;
        bus.start = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst/busy", 32'(bus.busy), 32'd0);
        chk("rst/done", 32'(bus.done), 32'd0);
        chk("rst/q",    32'(bus.myQValue), 32'd0);
        chk("rst/qh",   32'(bus.quotient_hop), 32'd0);
        chk("rst/qe",   32'(bus.quotient_energy), 32'd0);
        chk("rst/err",  32'(bus.div_error), 32'd0);
        @(negedge clk) rst = 1'b0;

        run("m0_hops2", 1'b0, 16'd2, 16'd75, 16'd50, 16'd150, '0, '0, '0, '0, '0,
            EN ? 16'd1536 : 16'd2048, 16'd2048, EN ? 16'd1024 : 16'd0, 1'b0, EN ? 58 : 30, 1);
        run("m1_basic", 1'b1, '0, '0, '0, '0, 16'd1024, 16'd2048, 16'd1024, 16'd2048, 16'd2048,
            16'd1536, 16'd2048, EN ? 16'd1024 : 16'd0, 1'b0, 3, 2);
        run("m1_sat", 1'b1, '0, '0, '0, '0, 16'd0, 16'd4096, 16'hFFFF, 16'd4096, 16'd4096,
            16'hFFFF, 16'd2048, EN ? 16'd1024 : 16'd0, 1'b0, 3, 0);
        run("m0_hops0", 1'b0, 16'd0, 16'd40, 16'd50, 16'd150, '0, '0, '0, '0, '0,
            16'd0, 16'd0, 16'd0, 1'b1, 2, 0);
        run("m0_clamp_hi", 1'b0, 16'd3, 16'd200, 16'd50, 16'd150, '0, '0, '0, '0, '0,
            EN ? 16'd2730 : 16'd1365, 16'd1365, EN ? 16'd4096 : 16'd0, 1'b0, 30, 0);
        run("m1_alpha_big", 1'b1, '0, '0, '0, '0, 16'd100, 16'd1234, 16'd500, 16'd5000, 16'd0,
            16'd500, 16'd1365, EN ? 16'd4096 : 16'd0, 1'b0, 3, 0);

        // Abort a mode 0 run with an asynchronous reset pulse
        @(negedge clk);
        drive(1'b0, 16'd2, 16'd75, 16'd50, 16'd150, '0, '0, '0, '0, '0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort/busy", 32'(bus.busy), 32'd0);
        chk("abort/done", 32'(bus.done), 32'd0);
        chk("abort/q",    32'(bus.myQValue), 32'd0);
        chk("abort/qh",   32'(bus.quotient_hop), 32'd0);
        chk("abort/qe",   32'(bus.quotient_energy), 32'd0);
        chk("abort/err",  32'(bus.div_error), 32'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        chk("abort/no_done", 32'(seen), 32'd0);

        run("m0_hops4", 1'b0, 16'd4, 16'd40, 16'd50, 16'd150, '0, '0, '0, '0, '0,
            EN ? 16'd512 : 16'd1024, 16'd1024, 16'd0, 1'b0, 30, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/qvalue_engine.md
# qvalue_engine

Sequential fixed-point Q-value unit for the EER-RL cluster-head/routing datapath. It computes a node's initial Q-value from residual energy and hop count, and applies the Q-learning update rule, using one shared bit-serial restoring divider and a registered multiply stage. It sits between the node energy/hop registers and the routing table that stores per-neighbour Q-values. It replaces the combinational hop-quotient calculation with a parametrised, multi-mode, handshaked engine.

## Interface
- WORD_WIDTH, 16, width of all data ports.
- FRAC_BITS, 12, fraction bits of the unsigned fixed-point format; 1.0 = 2^FRAC_BITS (4096 by default). Must satisfy FRAC_BITS < WORD_WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- mode  input  1  0 = initial Q computation, 1 = Q update.
- myEnergy, minEnergy, maxEnergy, hopsFromSink  input  WORD_WIDTH each  mode 0 operands (integers).
- oldQ, bestQ, reward, alpha, gamma  input  WORD_WIDTH each  mode 1 operands (fixed point).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results are valid and held until the next accepted start.
- myQValue  output  WORD_WIDTH  result Q.
- quotient_hop, quotient_energy  output  WORD_WIDTH  mode 0 component terms, each ≤ 2^FRAC_BITS.
- div_error  output  1  pulses with done when hopsFromSink == 0.

## Operation
- States: IDLE, DIV_HOP, DIV_EN, COMBINE, UPD_MUL, UPD_ACC, DONE.
- IDLE: when start=1, latch all operands. mode 0 goes to DIV_HOP; mode 1 goes to UPD_MUL.
- Divider: restoring, one quotient bit per cycle, DIV_BITS = WORD_WIDTH+FRAC_BITS iterations. Result is floor.
- DIV_HOP: quotient_hop = 2^FRAC_BITS / hopsFromSink. If hops == 0: no iterations run, quotient_hop = 0, div_error is set, and the FSM jumps straight to COMBINE.
- DIV_EN computes quotient_energy = ((myEnergy−minEnergy) << FRAC_BITS) / (maxEnergy−minEnergy), with these clamps:
  - myEnergy ≤ minEnergy: result is 0 and the state is skipped.
  - myEnergy ≥ maxEnergy or maxEnergy ≤ minEnergy: result is 2^FRAC_BITS and the state is skipped.
- COMBINE: myQValue = (quotient_hop + quotient_energy) >> 1, computed in WORD_WIDTH+1 bits. If div_error, myQValue = 0.
- UPD_MUL: target = reward + ((gamma·bestQ) >> FRAC_BITS), saturated to all-ones.
- UPD_ACC: newQ = (((2^FRAC_BITS−alpha)·oldQ + alpha·target) >> FRAC_BITS). Products are held in 2·WORD_WIDTH+1 bits; the result saturates to all-ones. If alpha > 2^FRAC_BITS, it is treated as 2^FRAC_BITS. quotient_* outputs are unchanged in mode 1.
- DONE: pulse done and div_error (if set), then return to IDLE.
- start while busy is ignored; no queuing.

## Timing
- Reset values: all outputs 0, FSM in IDLE, internal registers cleared. An asynchronous rst mid-operation aborts immediately; no done is produced.
- Start accepted at edge E0. busy=1 from E0 through the cycle done is high.
- Mode 0 with energy term, unclamped: done high after edge E0 + 2·DIV_BITS + 2 (58 cycles at defaults). Each skipped division removes DIV_BITS cycles.
- Mode 1: done high after edge E0 + 3.
- start may be asserted in the same cycle done is high: it is ignored. IDLE is entered on the following edge.
- A new start may be accepted the cycle after done.

## Configuration
- QVALUE_ENERGY_TERM_EN defined:
  - Mode 0 computes the hop and energy terms.
  - myQValue = (quotient_hop + quotient_energy) >> 1.
- QVALUE_ENERGY_TERM_EN undefined:
  - DIV_EN and its clamp logic are not built.
  - quotient_energy is tied to 0.
  - myQValue = quotient_hop.
  - Mode 0 latency is DIV_BITS + 2.
  - Energy ports remain but are unused.

## Test plan
- Mode 0, macro on, hops=2, myE=75, minE=50, maxE=150: quotient_hop=2048, quotient_energy=1024, myQValue=1536, done after 58 cycles, div_error=0.
- Same stimulus, macro off: myQValue=2048, quotient_energy=0, done after 30 cycles.
- Mode 0, hops=0, myE=40, minE=50: div_error and done pulse together; myQValue=0, quotient_energy=0, latency 2 cycles.
- Mode 1, oldQ=1024, alpha=2048, reward=1024, gamma=2048, bestQ=2048: myQValue=1536 three cycles after start.
- Mode 1, reward=0xFFFF, gamma=4096, bestQ=4096, alpha=4096: target saturates, myQValue=0xFFFF.
- rst pulse at cycle 10 of a mode 0 run:
  - All outputs return to 0 and busy drops, with no done.
  - A subsequent start with hops=4 and the macro off gives myQValue=1024.
